// File: rtl/display_pkg.sv
// Shared display types: BCD digit types, conversion FSM states and a decimal-limit helper.
package display_pkg;

   localparam int NDIG_DEF = 8;

   typedef logic [3:0] bcd_t;
   typedef bcd_t [NDIG_DEF-1:0] bcd_vec_t;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

   // Largest value representable in n decimal digits (10^n - 1).
   function automatic longint unsigned max_dec(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p - 1;
   endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// Shift-add-3 correction for one BCD digit: adds 3 when the digit is 5 or more.
module bcd_add3_nibble
   import display_pkg::*;
(
   input  bcd_t d_in,
   output bcd_t d_out
);

   assign d_out = (d_in >= 4'd5) ? d_in + 4'd3 : d_in;

endmodule

// File: rtl/bin2bcd_8digits_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking enabled by macro LEADING_ZERO_BLANK_EN.
module bin2bcd_8digits_seq
   import display_pkg::*;
#(
   parameter int BIN_W = 27,
   parameter int NDIG  = NDIG_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [BIN_W-1:0]  bin_in,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [4*NDIG-1:0] bcd_out,
   output logic [NDIG-1:0]   blank_mask
);

   localparam int              CNT_W   = $clog2(BIN_W + 1);
   localparam longint unsigned MAX_VAL = max_dec(NDIG);

   conv_state_t           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIN_W-1:0]      shreg_q, shreg_d;
   bcd_t [NDIG-1:0]       scratch_q, scratch_d;
   logic                  ovf_pend_q, ovf_pend_d;
   logic                  overflow_q, overflow_d;
   bcd_t [NDIG-1:0]       bcd_q, bcd_d;
   logic [NDIG-1:0]       blank_q, blank_d;

   bcd_t [NDIG-1:0]           adj;
   logic [4*NDIG+BIN_W-1:0]   cat_sh;
   bcd_t [NDIG-1:0]           scratch_fin;
   logic [BIN_W-1:0]          shreg_fin;
   logic [NDIG-1:0]           blank_calc;

   genvar gi;
   generate
      for (gi = 0; gi < NDIG; gi++) begin : g_add3
         bcd_add3_nibble u_add3 (
            .d_in  (scratch_q[gi]),
            .d_out (adj[gi])
         );
      end
   endgenerate

   assign cat_sh      = {adj, shreg_q} << 1;
   assign scratch_fin = cat_sh[4*NDIG+BIN_W-1:BIN_W];
   assign shreg_fin   = cat_sh[BIN_W-1:0];

   // Blank every digit above the most significant nonzero one; digit 0 always shows.
   always_comb begin
      blank_calc = '0;
`ifdef LEADING_ZERO_BLANK_EN
      begin
         logic all_zero;
         all_zero = 1'b1;
         for (int i = NDIG - 1; i > 0; i--) begin
            all_zero      = all_zero && (scratch_fin[i] == 4'd0);
            blank_calc[i] = all_zero;
         end
      end
`endif
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      scratch_d  = scratch_q;
      ovf_pend_d = ovf_pend_q;
      overflow_d = overflow_q;
      bcd_d      = bcd_q;
      blank_d    = blank_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = SHIFT;
               shreg_d    = bin_in;
               scratch_d  = '0;
               cnt_d      = CNT_W'(BIN_W);
               ovf_pend_d = 64'(bin_in) > MAX_VAL;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            scratch_d = scratch_fin;
            shreg_d   = shreg_fin;
            cnt_d     = cnt_q - 1'b1;
            // Last shift: publish result; an oversized input saturates to all nines.
            if (cnt_q == CNT_W'(1)) begin
               state_d    = DONE;
               overflow_d = ovf_pend_q;
               bcd_d      = ovf_pend_q ? {NDIG{4'd9}} : scratch_fin;
               blank_d    = ovf_pend_q ? '0 : blank_calc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shreg_q    <= '0;
         scratch_q  <= '0;
         ovf_pend_q <= 1'b0;
         overflow_q <= 1'b0;
         bcd_q      <= '0;
         blank_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         scratch_q  <= scratch_d;
         ovf_pend_q <= ovf_pend_d;
         overflow_q <= overflow_d;
         bcd_q      <= bcd_d;
         blank_q    <= blank_d;
      end
   end

   assign busy       = (state_q == SHIFT);
   assign done       = (state_q == DONE);
   assign overflow   = overflow_q;
   assign bcd_out    = bcd_q;
   assign blank_mask = blank_q;

endmodule

// File: tb/tb_bin2bcd_8digits_seq.sv
// Randomized self-checking bench for bin2bcd_8digits_seq against a decimal-arithmetic model.
module tb_bin2bcd_8digits_seq;

   localparam int BIN_W = 27;
   localparam int NDIG  = 8;
   localparam int LAT   = BIN_W + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [BIN_W-1:0]  bin_in = '0;
   logic              busy, done, overflow;
   logic [4*NDIG-1:0] bcd_out;
   logic [NDIG-1:0]   blank_mask;

   int total = 0;
   int bad   = 0;
   logic [31:0] prev_bcd = '0;

   bin2bcd_8digits_seq #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bin_in     (bin_in),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .bcd_out    (bcd_out),
      .blank_mask (blank_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain decimal arithmetic on the input value.
   function automatic logic [31:0] model_bcd(input longint unsigned v);
      logic [31:0] r;
      longint unsigned x;
      r = '0;
      if (v > 64'd99_999_999) return 32'h9999_9999;
      x = v;
      for (int i = 0; i < NDIG; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] model_blank(input longint unsigned v);
      logic [7:0] m;
      longint unsigned p;
      m = '0;
`ifdef LEADING_ZERO_BLANK_EN
      if (v <= 64'd99_999_999) begin
         p = 10;
         for (int i = 1; i < NDIG; i++) begin
            m[i] = (v < p);
            p = p * 10;
         end
      end
`else
      p = 0;
      if (v == p) m = '0;
`endif
      return m;
   endfunction

   // One conversion; optionally pokes a stray start and changes bin_in mid-shift.
   task automatic run_conv(input logic [BIN_W-1:0] v, input bit poke);
      int n;
      @(negedge clk);
      start  = 1'b1;
      bin_in = v;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      check("busy_first", busy, 1'b1);
      check("hold_bcd", bcd_out, prev_bcd);
      while (done !== 1'b1 && n < 100) begin
         if (poke && n == 5) begin
            start  = 1'b1;
            bin_in = 27'd7;
         end else if (poke && n == 6) begin
            start  = 1'b0;
            bin_in = BIN_W'($urandom);
         end
         @(negedge clk);
         n++;
      end
      check("latency", n, LAT);
      check("bcd", bcd_out, model_bcd(64'(v)));
      check("ovf", overflow, 64'(v) > 64'd99_999_999);
      check("blank", blank_mask, model_blank(64'(v)));
      check("busy_done", busy, 1'b0);
      $display("conv v=%0d bcd=%h ovf=%0b blank=%h cycles=%0d", v, bcd_out, overflow, blank_mask, n);
      prev_bcd = model_bcd(64'(v));
      @(negedge clk);
      check("done_pulse", done, 1'b0);
   endtask

   initial begin
      int n, gap, hits;
      logic [BIN_W-1:0] v;

      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_bcd", bcd_out, 32'h0);
      check("rst_blank", blank_mask, 8'h0);
      @(negedge clk);
      rst = 1'b0;

      run_conv(27'd12_345_678, 1'b0);
      run_conv(27'd0, 1'b0);
      run_conv(27'd99_999_999, 1'b0);
      run_conv(27'd100_000_000, 1'b0);
      run_conv(27'd42, 1'b1);
      run_conv(27'h7FF_FFFF, 1'b0);

      // Back-to-back: start held through DONE.
      @(negedge clk);
      start  = 1'b1;
      bin_in = 27'd5;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first", n, LAT);
      @(negedge clk);
      start = 1'b0;
      gap = 1;
      check("b2b_no_idle", busy, 1'b1);
      while (done !== 1'b1 && gap < 100) begin
         @(negedge clk);
         gap++;
      end
      check("b2b_gap", gap, LAT);
      check("b2b_bcd", bcd_out, 32'h0000_0005);
      $display("b2b v=5 bcd=%h gap=%0d", bcd_out, gap);
      prev_bcd = 32'h5;
      @(negedge clk);

      // Randomized conversions, some near the overflow boundary.
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 3) == 0) v = BIN_W'($urandom_range(99_999_990, 100_000_010));
         else if ($urandom_range(0, 3) == 0) v = BIN_W'($urandom_range(0, 999));
         else v = BIN_W'($urandom);
         run_conv(v, ($urandom_range(0, 2) == 0));
      end

      // Asynchronous reset mid-shift.
      @(negedge clk);
      start  = 1'b1;
      bin_in = 27'd87_654_321;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_bcd", bcd_out, 32'h0);
      check("arst_ovf", overflow, 1'b0);
      check("arst_blank", blank_mask, 8'h0);
      $display("reset mid-shift asserted");
      @(negedge clk);
      rst = 1'b0;
      prev_bcd = '0;
      hits = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) hits++;
      end
      check("arst_no_done", hits, 0);
      run_conv(27'd42, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
